// File: rtl/hog_block_feeder_if.sv
// Cell-stream input and 2x2 block-feature output bundle of the HOG block feeder.
// The slave modport is the feeder's view; master is the view of whoever drives cells and consumes blocks.
interface hog_block_feeder_if #(
  parameter int FEA_I = 4,
  parameter int FEA_F = 28,
  parameter int BLK_W = 13
);
  localparam int W = 9 * (FEA_I + FEA_F);

  logic             sof;
  logic [W-1:0]     cell_hist;
  logic             cell_valid;
  logic [W-1:0]     fea_a;
  logic [W-1:0]     fea_b;
  logic [W-1:0]     fea_c;
  logic [W-1:0]     fea_d;
  logic             o_valid;
  logic [BLK_W-1:0] blk_id;
  logic             frame_done;

  modport slave (
    input  sof, cell_hist, cell_valid,
    output fea_a, fea_b, fea_c, fea_d, o_valid, blk_id, frame_done
  );

  modport master (
    output sof, cell_hist, cell_valid,
    input  fea_a, fea_b, fea_c, fea_d, o_valid, blk_id, frame_done
  );
endinterface

// File: rtl/hog_block_feeder.sv
// Buffers one row of HOG cell histograms and emits every 2x2 cell block with a
// raster-order block index, one cycle after the block's bottom-right cell arrives.
module hog_block_feeder #(
  parameter int FEA_I   = 4,
  parameter int FEA_F   = 28,
  parameter int CELLS_X = 80,
  parameter int CELLS_Y = 60,
  parameter int BLK_W   = 13
) (
  input  logic               clk,
  input  logic               rst,
  hog_block_feeder_if.slave  bus
);
  localparam int W  = 9 * (FEA_I + FEA_F);
  localparam int CW = (CELLS_X > 1) ? $clog2(CELLS_X) : 1;
  localparam int RW = (CELLS_Y > 1) ? $clog2(CELLS_Y) : 1;

  typedef logic [W-1:0] hist_t;

  // Storage that is always rewritten before it is read out.
  hist_t linebuf_q [CELLS_X];
  hist_t prev_top_q, prev_cur_q;

  logic [CW-1:0]    col_q, col_d;
  logic [RW-1:0]    row_q, row_d;
  logic [BLK_W-1:0] blk_cnt_q, blk_cnt_d;

  hist_t            fea_a_q, fea_b_q, fea_c_q, fea_d_q;
  hist_t            fea_a_d, fea_b_d, fea_c_d, fea_d_d;
  logic             o_valid_q, o_valid_d;
  logic [BLK_W-1:0] blk_id_q, blk_id_d;
  logic             frame_done_q, frame_done_d;

  // Effective position of this cycle's cell: sof forces it to (0,0).
  logic [CW-1:0] c_eff;
  logic [RW-1:0] r_eff;
  hist_t         top;
  logic          last_col, last_row, emit, frame_end;

  // NOTE: always_comb uses blocking '=' with every output defaulted first, so no
  // latches are inferred; always_ff uses non-blocking '<=' so registers update together.
  always_comb begin
    c_eff     = bus.sof ? '0 : col_q;
    r_eff     = bus.sof ? '0 : row_q;
    top       = linebuf_q[c_eff];
    last_col  = (c_eff == CW'(CELLS_X - 1));
    last_row  = (r_eff == RW'(CELLS_Y - 1));
    emit      = bus.cell_valid && (r_eff != '0) && (c_eff != '0);
    frame_end = bus.cell_valid && last_col && last_row;

    col_d     = c_eff;
    row_d     = r_eff;
    blk_cnt_d = bus.sof ? '0 : blk_cnt_q;
    if (bus.cell_valid) begin
      if (last_col) begin
        col_d = '0;
        row_d = last_row ? '0 : r_eff + RW'(1);
      end else begin
        col_d = c_eff + CW'(1);
      end
    end
    if (emit)      blk_cnt_d = blk_cnt_q + BLK_W'(1);
    if (frame_end) blk_cnt_d = '0;

    fea_a_d      = fea_a_q;
    fea_b_d      = fea_b_q;
    fea_c_d      = fea_c_q;
    fea_d_d      = fea_d_q;
    blk_id_d     = blk_id_q;
    o_valid_d    = emit;
    frame_done_d = frame_end;
    if (emit) begin
      fea_a_d  = prev_top_q;
      fea_b_d  = top;
      fea_c_d  = prev_cur_q;
      fea_d_d  = bus.cell_hist;
      blk_id_d = blk_cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      col_q        <= '0;
      row_q        <= '0;
      blk_cnt_q    <= '0;
      fea_a_q      <= '0;
      fea_b_q      <= '0;
      fea_c_q      <= '0;
      fea_d_q      <= '0;
      o_valid_q    <= 1'b0;
      blk_id_q     <= '0;
      frame_done_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      blk_cnt_q    <= blk_cnt_d;
      fea_a_q      <= fea_a_d;
      fea_b_q      <= fea_b_d;
      fea_c_q      <= fea_c_d;
      fea_d_q      <= fea_d_d;
      o_valid_q    <= o_valid_d;
      blk_id_q     <= blk_id_d;
      frame_done_q <= frame_done_d;
    end
  end

  // NOTE: the line buffer and hold registers have no reset; a reset port on a
  // memory prevents RAM mapping, and no entry is emitted before it is rewritten.
  always_ff @(posedge clk) begin
    if (rst && bus.cell_valid) begin
      linebuf_q[c_eff] <= bus.cell_hist;
      prev_top_q       <= top;
      prev_cur_q       <= bus.cell_hist;
    end
  end

  assign bus.fea_a      = fea_a_q;
  assign bus.fea_b      = fea_b_q;
  assign bus.fea_c      = fea_c_q;
  assign bus.fea_d      = fea_d_q;
  assign bus.o_valid    = o_valid_q;
  assign bus.blk_id     = blk_id_q;
  assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_hog_block_feeder.sv
// Directed bench for hog_block_feeder on a 4x3-cell frame; every bin of cell (r,c) is 16*r+c.
module tb_hog_block_feeder;
  localparam int CX = 4;
  localparam int CY = 3;
  localparam int FI = 4;
  localparam int FF = 28;
  localparam int BW = 13;
  localparam int W  = 9 * (FI + FF);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hog_block_feeder_if #(.FEA_I(FI), .FEA_F(FF), .BLK_W(BW)) bus ();

  hog_block_feeder #(
    .FEA_I(FI), .FEA_F(FF), .CELLS_X(CX), .CELLS_Y(CY), .BLK_W(BW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;
  logic [W-1:0] last_d;

  function automatic logic [W-1:0] val(input int r, input int c);
    logic [31:0] b;
    b = 32'(16 * r + c);
    return {9{b}};
  endfunction

  // Inputs change 1 time unit after the edge; outputs are sampled at the same point.
  task automatic drive(input bit v, input bit s, input logic [W-1:0] d);
    bus.cell_valid = v;
    bus.sof        = s;
    bus.cell_hist  = d;
    @(posedge clk);
    #1;
  endtask

  // Feeds one frame from linear position 'start' and checks every output cycle.
  // alt_first: cell (0,0) of this frame carried val(1,2), which shows up as fea_a of block 0.
  task automatic run_frame(input string tag, input bit gaps, input int start, input bit alt_first);
    int pulses;
    int r, c;
    bit exp_v, exp_fd;
    logic [W-1:0] ea;
    pulses = 0;
    for (int i = start; i < CX * CY; i++) begin
      r = i / CX;
      c = i % CX;
      if (gaps) begin
        for (int g = 0; g < (i % 3); g++) begin
          drive(1'b0, 1'b0, '0);
          total++;
          if (bus.o_valid !== 1'b0 || bus.frame_done !== 1'b0 || bus.fea_d !== last_d) begin
            bad++;
            $display("FAIL %s gap(%0d,%0d): o_valid=%b frame_done=%b fea_d=%h, required 0 0 %h",
                     tag, r, c, bus.o_valid, bus.frame_done, bus.fea_d, last_d);
          end
        end
      end
      drive(1'b1, 1'b0, val(r, c));
      exp_v  = (r >= 1) && (c >= 1);
      exp_fd = (r == CY - 1) && (c == CX - 1);
      total++;
      if (bus.o_valid !== exp_v) begin
        bad++;
        $display("FAIL %s o_valid(%0d,%0d): got %b want %b", tag, r, c, bus.o_valid, exp_v);
      end
      total++;
      if (bus.frame_done !== exp_fd) begin
        bad++;
        $display("FAIL %s frame_done(%0d,%0d): got %b want %b", tag, r, c, bus.frame_done, exp_fd);
      end
      if (exp_v) begin
        pulses++;
        ea = (alt_first && r == 1 && c == 1) ? val(1, 2) : val(r - 1, c - 1);
        total++;
        if (bus.fea_a !== ea) begin
          bad++;
          $display("FAIL %s fea_a(%0d,%0d): got %h want %h", tag, r, c, bus.fea_a, ea);
        end
        total++;
        if (bus.fea_b !== val(r - 1, c)) begin
          bad++;
          $display("FAIL %s fea_b(%0d,%0d): got %h want %h", tag, r, c, bus.fea_b, val(r - 1, c));
        end
        total++;
        if (bus.fea_c !== val(r, c - 1)) begin
          bad++;
          $display("FAIL %s fea_c(%0d,%0d): got %h want %h", tag, r, c, bus.fea_c, val(r, c - 1));
        end
        total++;
        if (bus.fea_d !== val(r, c)) begin
          bad++;
          $display("FAIL %s fea_d(%0d,%0d): got %h want %h", tag, r, c, bus.fea_d, val(r, c));
        end
        total++;
        if (bus.blk_id !== BW'((r - 1) * (CX - 1) + (c - 1))) begin
          bad++;
          $display("FAIL %s blk_id(%0d,%0d): got %0d want %0d", tag, r, c, bus.blk_id,
                   (r - 1) * (CX - 1) + (c - 1));
        end
        last_d = val(r, c);
      end
    end
    total++;
    if (pulses != (CX - 1) * (CY - 1) - ((start > CX + 1) ? 1 : 0)) begin
      bad++;
      $display("FAIL %s pulse_count: got %0d want %0d", tag, pulses, (CX - 1) * (CY - 1));
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    total++;
    if (bus.o_valid !== 1'b0 || bus.frame_done !== 1'b0 || bus.blk_id !== '0) begin
      bad++;
      $display("FAIL %s flags: o_valid=%b frame_done=%b blk_id=%0d, required 0 0 0",
               tag, bus.o_valid, bus.frame_done, bus.blk_id);
    end
    total++;
    if (bus.fea_a !== '0 || bus.fea_b !== '0 || bus.fea_c !== '0 || bus.fea_d !== '0) begin
      bad++;
      $display("FAIL %s fea_zero: a=%h d=%h, required all zero", tag, bus.fea_a, bus.fea_d);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    drive(1'b0, 1'b0, '0);
    drive(1'b0, 1'b0, '0);
    check_zero_outputs("reset");
    rst    = 1'b1;
    last_d = '0;
  endtask

  task automatic test_full_frame();
    run_frame("full", 1'b0, 0, 1'b0);
  endtask

  task automatic test_gaps();
    run_frame("gaps", 1'b1, 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_frame("b2b_f1", 1'b0, 0, 1'b0);
    run_frame("b2b_f2", 1'b0, 0, 1'b0);
  endtask

  task automatic test_sof();
    for (int i = 0; i < CX + 2; i++) begin
      drive(1'b1, 1'b0, val(i / CX, i % CX));
      total++;
      if (bus.frame_done !== 1'b0) begin
        bad++;
        $display("FAIL sof partial frame_done at %0d: got %b want 0", i, bus.frame_done);
      end
    end
    total++;
    if (bus.o_valid !== 1'b1 || bus.blk_id !== '0) begin
      bad++;
      $display("FAIL sof partial block0: o_valid=%b blk_id=%0d want 1 0", bus.o_valid, bus.blk_id);
    end
    last_d = val(1, 1);
    drive(1'b1, 1'b1, val(1, 2));
    total++;
    if (bus.o_valid !== 1'b0 || bus.frame_done !== 1'b0 || bus.fea_d !== last_d) begin
      bad++;
      $display("FAIL sof cell: o_valid=%b frame_done=%b fea_d=%h, required 0 0 %h",
               bus.o_valid, bus.frame_done, bus.fea_d, last_d);
    end
    run_frame("sof_new", 1'b0, 1, 1'b1);
  endtask

  task automatic test_sof_idle();
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, val(0, i));
    drive(1'b0, 1'b1, '0);
    total++;
    if (bus.o_valid !== 1'b0 || bus.frame_done !== 1'b0) begin
      bad++;
      $display("FAIL sof_idle: o_valid=%b frame_done=%b want 0 0", bus.o_valid, bus.frame_done);
    end
    run_frame("sof_idle_new", 1'b0, 0, 1'b0);
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < CX + 2; i++) drive(1'b1, 1'b0, val(i / CX, i % CX));
    rst = 1'b0;
    drive(1'b1, 1'b0, val(1, 2));
    check_zero_outputs("reset_mid");
    rst    = 1'b1;
    last_d = '0;
    run_frame("post_reset", 1'b0, 0, 1'b0);
  endtask

  initial begin
    bus.cell_valid = 1'b0;
    bus.sof        = 1'b0;
    bus.cell_hist  = '0;
    rst            = 1'b0;
    last_d         = '0;
    test_reset();
    test_full_frame();
    test_gaps();
    test_back_to_back();
    test_sof();
    test_sof_idle();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
